// File: rtl/instruction_executor.sv
// Multi-cycle execute engine: fetch, decode and execute ADDI/ADD/MUL/SW
// against a 32x32 register file, halting after PROG_LEN instructions.
module instruction_executor #(
    parameter int PROG_LEN = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        fetch_en,
    output logic        mem_wr,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  retired
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MULW,
        HALT
    } state_t;

    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ADD  = 6'b010000;
    localparam logic [5:0] OP_MUL  = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b111000;
    localparam logic [7:0] LAST    = 8'(PROG_LEN);

    state_t state, state_nx;

    logic [31:0] ir;
    logic [31:0] rf [32];
    logic [31:0] mcand, mplier, acc;
    logic [4:0]  cnt;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, rs_val, rt_val, mul_term;
    logic        is_addi, is_add, is_mul, is_sw;
    logic        last, mul_end, retire;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_val;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign simm   = {{16{ir[15]}}, ir[15:0]};
    assign rs_val = rf[rs];
    assign rt_val = rf[rt];

    assign is_addi = (op == OP_ADDI);
    assign is_add  = (op == OP_ADD);
    assign is_mul  = (op == OP_MUL);
    assign is_sw   = (op == OP_SW);

    assign last     = (retired + 8'd1) == LAST;
    assign mul_end  = (state == MULW) && (cnt == 5'd31);
    assign mul_term = mplier[0] ? mcand : 32'd0;
    assign retire   = ((state == EXEC) && !is_mul) || mul_end;

    assign fetch_en = (state == FETCH);
    assign busy     = (state != IDLE) && (state != HALT);
    assign done     = (state == HALT);
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = FETCH;
            FETCH: state_nx = EXEC;
            EXEC: begin
                if (is_mul)    state_nx = MULW;
                else if (last) state_nx = HALT;
                else           state_nx = FETCH;
            end
            MULW: begin
                if (mul_end) state_nx = last ? HALT : FETCH;
            end
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    // Single write port shared by EXEC results and the final MUL step.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = 5'd0;
        wr_val = 32'd0;
        if (state == EXEC && is_addi) begin
            wr_en  = 1'b1;
            wr_idx = rt;
            wr_val = rs_val + simm;
        end else if (state == EXEC && is_add) begin
            wr_en  = 1'b1;
            wr_idx = rd;
            wr_val = rs_val + rt_val;
        end else if (mul_end) begin
            wr_en  = 1'b1;
            wr_idx = rd;
            wr_val = acc + mul_term;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (wr_en && wr_idx != 5'd0) begin
            rf[wr_idx] <= wr_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir        <= 32'd0;
            retired   <= 8'd0;
            mem_wr    <= 1'b0;
            mem_addr  <= 8'd0;
            mem_wdata <= 32'd0;
        end else begin
            if (state == FETCH) ir <= instr;
            if (retire) retired <= retired + 8'd1;
            mem_wr <= (state == EXEC) && is_sw;
            if (state == EXEC && is_sw) begin
                mem_addr  <= 8'(rs_val + simm);
                mem_wdata <= rt_val;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 32'd0;
            cnt    <= 5'd0;
        end else if (state == EXEC && is_mul) begin
            mcand  <= rs_val;
            mplier <= rt_val;
            acc    <= 32'd0;
            cnt    <= 5'd0;
        end else if (state == MULW) begin
            acc    <= acc + mul_term;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
        end
    end

endmodule

// File: doc/instruction_executor.md
# instruction_executor

Multi-cycle execute engine that sits downstream of the instruction fetch unit. It drives the fetcher's `control` input as `fetch_en`, captures the 32-bit instruction the fetcher presents in that same cycle, and decodes and executes it against a 32×32 register file. Supported operations are ADDI, ADD, iterative MUL and store-to-port. It stops after a fixed program length and reports completion.

## Interface
- `PROG_LEN`, default 6: number of instructions fetched and retired before halting (1..255).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clock `clk`.
- `instr` input 32: instruction word from the fetcher; valid only in cycles where `fetch_en` = 1.
- `fetch_en` output 1: connects to the fetcher `control`. High for exactly one cycle per instruction.
- `mem_wr` output 1: one-cycle store strobe.
- `mem_addr` output 8: store address.
- `mem_wdata` output 32: store data.
- `dbg_addr` input 5: register-file debug read index.
- `dbg_data` output 32: combinational `rf[dbg_addr]`. Reads 0 for index 0.
- `busy` output 1: high from leaving IDLE until HALT.
- `done` output 1: high in HALT.
- `retired` output 8: count of instructions retired.

## Operation
- Instruction fields:
  - `op` = `instr[31:26]`, `rs` = `[25:21]`, `rt` = `[20:16]`, `rd` = `[15:11]`, `imm` = `[15:0]`.
  - `simm` = `imm` sign-extended to 32 bits.
- Opcodes:
  - 110000 ADDI: `rf[rt]` = `rf[rs]` + `simm`.
  - 010000 ADD: `rf[rd]` = `rf[rs]` + `rf[rt]`.
  - 100000 MUL: `rf[rd]` = low 32 bits of `rf[rs]` × `rf[rt]`.
  - 111000 SW: `mem_addr` = (`rf[rs]` + `simm`)[7:0], `mem_wdata` = `rf[rt]`, `mem_wr` = 1.
  - Any other opcode, including 000000: NOP.
- Register r0 is hardwired to zero; writes to it are discarded.
- All arithmetic is 32-bit modulo 2^32 and unsigned for MUL; overflow is silently dropped.
- States:
  - IDLE: entered on reset; always goes to FETCH after one cycle.
  - FETCH: `fetch_en` = 1; `instr` latched into IR at the edge → EXEC.
  - EXEC: ADDI, ADD, SW and NOP complete at the edge and `retired` increments. MUL loads multiplicand, multiplier and a zeroed accumulator, then → MULW. Otherwise, if `retired`+1 = `PROG_LEN` → HALT, else → FETCH.
  - MULW: 32 iterations of shift-add with a 5-bit counter. On the counter = 31 edge, write `rf[rd]` and increment `retired`, then → HALT or FETCH by the same rule.
  - HALT: terminal; `done` = 1, `busy` = 0; held until reset.
- Register-file writes and `mem_wr` both happen at the EXEC (or final MULW) edge. Operands are read from the register file in EXEC, so results from the previous instruction are always visible and no forwarding is needed.

## Timing
- Reset values:
  - `fetch_en`, `mem_wr`, `busy`, `done` = 0.
  - `mem_addr`, `mem_wdata`, `retired`, IR and all registers = 0.
  - State = IDLE.
- `mem_wr`, `mem_addr` and `mem_wdata` are registered. They are valid the cycle after EXEC of SW, and `mem_wr` is high for exactly 1 cycle.
- Latency per instruction:
  - Non-MUL: 2 cycles (FETCH, EXEC).
  - MUL: 34 cycles (FETCH, EXEC, 32×MULW).
- `fetch_en` is high only in FETCH. The fetcher advances its pc on that same edge, so exactly one pc increment occurs per instruction.
- `instr` is sampled only at the FETCH edge and ignored in all other states.
- Reset asserted mid-MUL or mid-program: all state, registers and the counter clear immediately. The fetcher shares `reset`, so both restart at pc 0.
- `dbg_data` has zero-cycle latency and reflects writes from the cycle after they occur.

## Test plan
- Reference program with `PROG_LEN` = 6:
  - Instructions, in order: ADDI r10=10; ADDI r15=15; ADD r25=r10+r15; SW rs=25 rt=20 imm=5; ADDI r5=2; MUL r30=r25×r5.
  - Required: r10=10, r15=15, r25=25, r5=2, r30=50.
  - One `mem_wr` pulse with `mem_addr`=30, `mem_wdata`=0.
  - `done` high 1+44 cycles after reset release; `retired`=6.
- ADDI with rs=r0, rt=r3, imm=0xFFFF: `rf[3]`=0xFFFFFFFF. ADDI with rt=r0: r0 stays 0.
- MUL overflow: r1=0x10000, r2=0x10000, MUL r4: `rf[4]`=0. MUL 7×0xFFFFFFFF: result 0xFFFFFFF9.
- Unknown opcode 0x3F and all-zero word: no register or `mem_wr` change, 2 cycles each, `retired` increments.
- Reset asserted at MULW cycle 10: all outputs 0 immediately. After release the first `fetch_en` occurs on the second cycle (after one IDLE cycle), and the program re-runs correctly.
- `fetch_en` pulse count equals `PROG_LEN` exactly, and it never asserts in HALT across 100 extra cycles.
